// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, widths and helpers for the data-memory master.
// Widths come from `DSIZE (data) and `MEM_SPACE (word address); both
// fall back to local defaults when the build does not provide them.
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

package dmem_pkg;

  localparam int DMEM_DW = `DSIZE;
  localparam int DMEM_AW = `MEM_SPACE;
  localparam int LEN_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } dmem_state_e;

  // True when a beat count has no further beats to run.
  function automatic logic len_is_zero(input logic [LEN_W-1:0] len);
    return (len == {LEN_W{1'b0}});
  endfunction

endpackage

// File: rtl/dmem_burst_ctr.sv
// dmem_burst_ctr: remaining-beat counter plus wrapping word-address register.
// The address register is the memory address port, so it is a registered
// output; stepping it past the top of the address space wraps to zero.
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module dmem_burst_ctr
  import dmem_pkg::*;
#(
  parameter int AW = `MEM_SPACE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             dec_en,
  input  logic             inc_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [LEN_W-1:0] load_len,
  output logic [AW-1:0]    addr,
  output logic             last
);

  logic [LEN_W-1:0] cnt_r;
  logic [AW-1:0]    addr_r;

  // Beat counter: loaded on request acceptance, counts down one per beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (load_en) begin
      cnt_r <= load_len;
    end else if (dec_en && !len_is_zero(cnt_r)) begin
      cnt_r <= cnt_r - LEN_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Word address: loaded on acceptance, stepped modulo 2^AW between beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r <= {AW{1'b0}};
    end else if (load_en) begin
      addr_r <= load_addr;
    end else if (inc_en) begin
      addr_r <= addr_r + AW'(1'b1);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr = addr_r;
  assign last = len_is_zero(cnt_r);

endmodule

// File: rtl/dmem_master.sv
// dmem_master: initiator-side controller for the single-port data memory.
// Accepts load/store requests, drives the memory port for one ISSUE cycle,
// absorbs the memory's one-cycle read latency and returns read data over a
// valid/ready channel. Define DMEM_BURST_EN to honour req_len on loads;
// without it every load is a single beat and rsp_last follows rsp_valid.
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module dmem_master
  import dmem_pkg::*;
#(
  parameter int AW = `MEM_SPACE,
  parameter int DW = `DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_last,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_we,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy
);

`ifdef DMEM_BURST_EN
  localparam logic BURST_EN = 1'b1;
`else
  localparam logic BURST_EN = 1'b0;
`endif

  dmem_state_e      state_r, state_nxt_s;
  logic             req_ready_r, busy_r, mem_we_r, rsp_valid_r, rsp_last_r;
  logic [DW-1:0]    mem_wdata_r, rsp_rdata_r;
  logic             mem_we_nxt_s, rsp_valid_nxt_s, rsp_last_nxt_s;
  logic [DW-1:0]    mem_wdata_nxt_s, rsp_rdata_nxt_s;
  logic             ctr_load_s, ctr_step_s, ctr_last_s;
  logic [LEN_W-1:0] len_load_s;

  // Stores are always single-beat; loads take req_len only when bursts exist.
  assign len_load_s = req_we ? {LEN_W{1'b0}} : (req_len & {LEN_W{BURST_EN}});

  dmem_burst_ctr #(.AW(AW)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load_en   (ctr_load_s),
    .dec_en    (ctr_step_s),
    .inc_en    (ctr_step_s),
    .load_addr (req_addr),
    .load_len  (len_load_s),
    .addr      (mem_addr),
    .last      (ctr_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; mem_we_r high in ISSUE marks the request as a store.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_nxt_s = ST_ISSUE;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (mem_we_r) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_CAPTURE;
      end
      ST_CAPTURE: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready && ctr_last_s)  state_nxt_s = ST_IDLE;
        else if (rsp_ready)           state_nxt_s = ST_ISSUE;
        else                          state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values and counter controls for each state.
  always_comb begin
    mem_we_nxt_s    = 1'b0;
    mem_wdata_nxt_s = mem_wdata_r;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_rdata_nxt_s = rsp_rdata_r;
    rsp_last_nxt_s  = rsp_last_r;
    ctr_load_s      = 1'b0;
    ctr_step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          mem_we_nxt_s    = req_we;
          mem_wdata_nxt_s = req_wdata;
          ctr_load_s      = 1'b1;
        end else begin
          ctr_load_s      = 1'b0;
        end
      end
      ST_ISSUE: begin
        mem_we_nxt_s = 1'b0;
      end
      ST_CAPTURE: begin
        rsp_valid_nxt_s = 1'b1;
        rsp_rdata_nxt_s = mem_rdata;
`ifdef DMEM_BURST_EN
        rsp_last_nxt_s  = ctr_last_s;
`else
        rsp_last_nxt_s  = 1'b1;
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt_s = 1'b0;
          rsp_last_nxt_s  = 1'b0;
          ctr_step_s      = !ctr_last_s;
        end else begin
          rsp_valid_nxt_s = rsp_valid_r;
        end
      end
      default: begin
        rsp_valid_nxt_s = 1'b0;
        rsp_last_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output registers; async reset drops mem_we so an in-flight store is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DW{1'b0}};
      rsp_last_r  <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      mem_we_r    <= mem_we_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      rsp_last_r  <= rsp_last_nxt_s;
    end
  end

  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_last  = rsp_last_r;

endmodule

// File: tb/tb_dmem_master.sv
// tb_dmem_master: directed bench for dmem_master with a registered-read
// memory model, a reference memory image and a response scoreboard queue.
`timescale 1ns/1ps

module tb_dmem_master;
  import dmem_pkg::*;

  localparam int AW = DMEM_AW;
  localparam int DW = DMEM_DW;
`ifdef DMEM_BURST_EN
  localparam int BURST_BEATS = 4;
`else
  localparam int BURST_BEATS = 1;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_wdata;
  logic [LEN_W-1:0] req_len;
  logic             rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0]    rsp_rdata;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;
  logic             mem_we, busy;

  logic [DW-1:0] sim_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  exp_t          exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            resp_count = 0;

  always #5 clk = ~clk;

  dmem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_we) sim_mem[mem_addr] <= mem_wdata;
    mem_rdata <= sim_mem[mem_addr];
  end

  // Cycle counter used to measure request acceptance spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted response beat is popped and compared.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      exp_t e;
      resp_count++;
      check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
        check("rsp_last", 32'(rsp_last), 32'(e.last));
      end
    end
  end

  task automatic expect_load(input logic [AW-1:0] addr, input int beats);
    exp_t e;
    logic [AW-1:0] a;
    a = addr;
    for (int i = 0; i < beats; i++) begin
      e.data = ref_mem[a];
      e.last = (i == beats - 1);
      exp_q.push_back(e);
      a = a + AW'(1);
    end
  endtask

  // Present a request, wait for acceptance, check the ISSUE cycle port.
  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [LEN_W-1:0] len, output int acc_cyc);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_len = len;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    check("issue_we", 32'(mem_we), 32'(we));
    check("issue_addr", 32'(mem_addr), 32'(addr));
    if (we) check("issue_wdata", 32'(mem_wdata), 32'(wdata));
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int a0, a1, a2, rc0, we_cnt;
    logic [AW-1:0] top2;
    top2 = '1;
    top2 = top2 - AW'(1);
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_last", 32'(rsp_last), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Store 0x1234 to 5, then load it back.
    ref_mem[5] = 16'h1234;
    send(1'b1, AW'(5), 16'h1234, 2'd0, a0);
    @(posedge clk); #1;
    check("store_we_one_cycle", 32'(mem_we), 32'd0);
    check("store_back_idle", 32'(req_ready), 32'd1);
    check("store_written", 32'(sim_mem[5]), 32'h1234);
    expect_load(AW'(5), 1);
    rc0 = resp_count;
    send(1'b0, AW'(5), 16'h0000, 2'd0, a0);
    @(posedge clk); #1;
    check("load_valid_e1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("load_valid_e2", 32'(rsp_valid), 32'd1);
    check("load_rdata_e2", 32'(rsp_rdata), 32'h1234);
    check("load_last_e2", 32'(rsp_last), 32'd1);
    @(posedge clk); #1;
    check("load_valid_cleared", 32'(rsp_valid), 32'd0);
    check("load_one_rsp", 32'(resp_count - rc0), 32'd1);
    check("load_back_idle", 32'(req_ready), 32'd1);

    // Back-pressure: rsp_ready low for 6 cycles.
    rsp_ready = 1'b0;
    expect_load(AW'(5), 1);
    send(1'b0, AW'(5), 16'h0000, 2'd0, a0);
    repeat (2) @(posedge clk);
    #1;
    rc0 = resp_count;
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", 32'(rsp_rdata), 32'h1234);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_one_rsp", 32'(resp_count - rc0), 32'd1);
    @(posedge clk); #1;
    check("stall_no_reissue", 32'(resp_count - rc0), 32'd1);
    check("stall_valid_low", 32'(rsp_valid), 32'd0);

    // Wrapping load of req_len = 3 from 2^AW-2.
    for (int i = 0; i < 4; i++) begin
      ref_mem[top2 + AW'(i)] = DW'(16'hA000 + i);
      send(1'b1, top2 + AW'(i), DW'(16'hA000 + i), 2'd0, a0);
    end
    @(posedge clk); #1;
    rc0 = resp_count;
    expect_load(top2, BURST_BEATS);
    send(1'b0, top2, 16'h0000, 2'd3, a0);
    drain("burst_drained", 60);
    check("burst_beats", 32'(resp_count - rc0), 32'(BURST_BEATS));
    check("burst_back_idle", 32'(req_ready), 32'd1);

    // Store with req_len = 3 is a single write with no response.
    rc0 = resp_count;
    ref_mem[32] = 16'hBEEF;
    send(1'b1, AW'(32), 16'hBEEF, 2'd3, a0);
    we_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_we) we_cnt++;
    end
    check("store_len_extra_we", 32'(we_cnt), 32'd0);
    check("store_len_written", 32'(sim_mem[32]), 32'hBEEF);
    check("store_len_no_rsp", 32'(resp_count - rc0), 32'd0);

    // Reset during the ISSUE cycle of a store.
    ref_mem[48] = 16'h1111;
    send(1'b1, AW'(48), 16'h1111, 2'd0, a0);
    send(1'b1, AW'(48), 16'h2222, 2'd0, a0);
    rst = 1'b0;
    #1;
    check("rst_issue_mem_we", 32'(mem_we), 32'd0);
    check("rst_issue_req_ready", 32'(req_ready), 32'd1);
    check("rst_issue_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_issue_mem_kept", 32'(sim_mem[48]), 32'(ref_mem[48]));

    // Reset while a load is waiting in RESP.
    rsp_ready = 1'b0;
    expect_load(top2, BURST_BEATS);
    send(1'b0, top2, 16'h0000, 2'd3, a0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_burst_valid_before", 32'(rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_burst_valid", 32'(rsp_valid), 32'd0);
    check("rst_burst_busy", 32'(busy), 32'd0);
    check("rst_burst_req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_idle", 32'(req_ready), 32'd1);

    // Back-to-back store, store, load.
    ref_mem[64] = 16'h4444;
    ref_mem[65] = 16'h5555;
    send(1'b1, AW'(64), 16'h4444, 2'd0, a0);
    send(1'b1, AW'(65), 16'h5555, 2'd0, a1);
    expect_load(AW'(65), 1);
    send(1'b0, AW'(65), 16'h0000, 2'd0, a2);
    check("b2b_store_spacing", 32'(a1 - a0), 32'd2);
    check("b2b_load_spacing", 32'(a2 - a1), 32'd2);
    drain("b2b_drained", 20);
    check("b2b_mem64", 32'(sim_mem[64]), 32'h4444);
    check("b2b_mem65", 32'(sim_mem[65]), 32'h5555);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
# dmem_master

Initiator-side controller for the data memory: accepts load/store requests from the CPU MEM stage over a valid/ready handshake and drives the memory's `address`/`data_in`/`write_en` port. It absorbs the memory's one-cycle registered read latency and returns read data over a second valid/ready channel with back-pressure. Optionally, it issues short read bursts.

## Interface
- `AW`, default `` `MEM_SPACE ``: word-address width.
- `DW`, default `` `DSIZE `` (16): data width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  DW  store data.
- `req_len`  in  2  burst beats minus one (loads only).
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer accepts read data.
- `rsp_rdata`  out  DW  read data.
- `rsp_last`  out  1  final beat of a load.
- `mem_addr`  out  AW  to memory `address`.
- `mem_wdata`  out  DW  to memory `data_in`.
- `mem_we`  out  1  to memory `write_en`, active-high.
- `mem_rdata`  in  DW  from memory `data_out`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- All outputs are registered.
- Reset values: all outputs 0 except `req_ready`, which is 1. State is IDLE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: latch the request, drive `mem_addr`/`mem_wdata`, set `mem_we` = `req_we`, load the beat counter from `req_len`, and go to ISSUE.
- **ISSUE**
  - The memory samples the port at the end of this cycle.
  - `mem_we` is high for exactly this one cycle.
  - Store: go to IDLE. Stores are posted and produce no response.
  - Load: go to CAPTURE.
- **CAPTURE**
  - `mem_rdata` is valid.
  - Register it into `rsp_rdata`, set `rsp_valid` = 1, and set `rsp_last` = (beat counter == 0).
  - Go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_rdata` and `rsp_last` stable until `rsp_ready`.
  - On handshake with beats remaining: decrement the counter, set `mem_addr` = `mem_addr` + 1 modulo 2^AW (0x…FF wraps to 0), and go to ISSUE.
  - On handshake with no beats remaining: clear `rsp_valid` and go to IDLE.
- The controller never issues a read and a write in the same cycle.
- `req_len` is ignored for stores; each store is a single beat.
- Asynchronous reset mid-operation:
  - All state clears immediately and any in-progress burst is abandoned without a response.
  - `mem_we` drops before the next edge, so a store in ISSUE during reset is not performed.

## Timing
- Request accepted at edge E0. ISSUE runs in cycle E0–E1; the memory samples at E1.
- Load: capture at E2; `rsp_valid` high from E2. Load latency is 2 cycles after acceptance.
- Store: back in IDLE after E1. Store throughput is one store per 2 cycles.
- Single load with `rsp_ready` held high: one load per 4 cycles.
- Burst with `rsp_ready` held high: one beat per 3 cycles.
- `rsp_ready` low stalls indefinitely in RESP. No data is lost or reissued.
- `req_valid` arriving while busy waits; `req_ready` = 0 outside IDLE.

## Configuration
- `DMEM_BURST_EN` defined:
  - `req_len` is honoured; a load returns `req_len`+1 beats at consecutive wrapping addresses.
  - `rsp_last` is high only on the final beat.
- `DMEM_BURST_EN` undefined:
  - `req_len` is present but ignored.
  - Every load is a single beat and `rsp_last` is tied to `rsp_valid`.

## Structure
- Shared package `dmem_pkg`:
  - state encoding IDLE/ISSUE/CAPTURE/RESP (2 bits);
  - `LEN_W` = 2;
  - widths derived from `` `DSIZE `` and `` `MEM_SPACE ``.
- One sub-module, `dmem_burst_ctr`:
  - beat counter plus wrapping address incrementer;
  - load, decrement and increment enables;
  - `last` output.
- The controller FSM lives in `dmem_master`.

## Test plan
- Store 0x1234 to address 5, then load address 5 → `mem_we` high for exactly one cycle with `mem_addr` = 5; `rsp_rdata` = 0x1234, `rsp_last` = 1, `rsp_valid` high 2 cycles after load acceptance.
- Load with `rsp_ready` held low for 6 cycles → `rsp_valid` and data stay stable throughout; `req_ready` = 0; exactly one response after `rsp_ready` rises.
- Burst (`DMEM_BURST_EN`), `req_len` = 3, start at 2^AW−2 → 4 beats from addresses 2^AW−2, 2^AW−1, 0, 1; `rsp_last` only on the 4th beat.
- Store with `req_len` = 3 → single write; `mem_we` asserted for one cycle only; no response.
- `rst` asserted during ISSUE of a store → outputs reset immediately and the memory location is unchanged; `rst` asserted mid-burst → `rsp_valid` = 0 and the controller returns to IDLE with `req_ready` = 1.
- Back-to-back `req_valid` (store, store, load) → accepted at 2-cycle spacing for the stores; all three executed in order.
